// File: rtl/frame_countdown_timer_if.sv
// Signal bundle between the game controller / frame-rate counter and frame_countdown_timer.
// Defining FRAME_TIMER_WARN_EN adds the o_warn low-time indicator.
interface frame_countdown_timer_if #(
  parameter int SEC_W = 7
);
  logic             i_tick;
  logic             i_start;
  logic             i_pause;
  logic [SEC_W-1:0] i_load_secs;
  logic             i_ack;
  logic             o_tick_en;
  logic [SEC_W-1:0] o_secs_left;
  logic [3:0]       o_bcd_tens;
  logic [3:0]       o_bcd_ones;
  logic [1:0]       o_state;
  logic             o_busy;
  logic             o_expired;

`ifdef FRAME_TIMER_WARN_EN
  logic             o_warn;

  modport master (
    output i_tick, i_start, i_pause, i_load_secs, i_ack,
    input  o_tick_en, o_secs_left, o_bcd_tens, o_bcd_ones, o_state, o_busy, o_expired, o_warn
  );

  modport slave (
    input  i_tick, i_start, i_pause, i_load_secs, i_ack,
    output o_tick_en, o_secs_left, o_bcd_tens, o_bcd_ones, o_state, o_busy, o_expired, o_warn
  );
`else
  modport master (
    output i_tick, i_start, i_pause, i_load_secs, i_ack,
    input  o_tick_en, o_secs_left, o_bcd_tens, o_bcd_ones, o_state, o_busy, o_expired
  );

  modport slave (
    input  i_tick, i_start, i_pause, i_load_secs, i_ack,
    output o_tick_en, o_secs_left, o_bcd_tens, o_bcd_ones, o_state, o_busy, o_expired
  );
`endif
endinterface

// File: rtl/frame_countdown_timer.sv
// Whole-second start/pause/expire countdown driven by frame ticks, with BCD readout.
// Optional FRAME_TIMER_WARN_EN adds a registered o_warn for the last five seconds of a run.
module frame_countdown_timer #(
  parameter int FRAMES_PER_SEC = 60,
  parameter int SEC_W          = 7,
  parameter int MAX_SECS       = 99
) (
  input  logic                    clk,
  input  logic                    reset,
  frame_countdown_timer_if.slave  io_bus
);

  localparam int                 FRAME_W    = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(FRAMES_PER_SEC - 1);
  localparam logic [SEC_W-1:0]   MAX_LOAD   = SEC_W'(MAX_SECS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [SEC_W-1:0]   r_secs;
  logic [SEC_W-1:0]   w_next_secs;
  logic [SEC_W-1:0]   w_load_clamped;
  logic [FRAME_W-1:0] r_frame_cnt;
  logic [FRAME_W-1:0] w_next_frame_cnt;
  logic               r_tick_en;
  logic               r_expired;
  logic               w_expire_now;
  logic [3:0]         w_tens;

  assign w_load_clamped = (io_bus.i_load_secs > MAX_LOAD) ? MAX_LOAD : io_bus.i_load_secs;

  // start overrides everything; otherwise the current state decides, pause beating tick
  always_comb begin
    w_next_state     = r_state;
    w_next_secs      = r_secs;
    w_next_frame_cnt = r_frame_cnt;
    w_expire_now     = 1'b0;
    if (io_bus.i_start) begin
      w_next_secs      = w_load_clamped;
      w_next_frame_cnt = '0;
      if (w_load_clamped == '0) begin
        w_next_state = EXPIRED;
        w_expire_now = 1'b1;
      end else begin
        w_next_state = RUN;
      end
    end else begin
      unique case (r_state)
        IDLE: begin
        end
        RUN: begin
          if (io_bus.i_pause) begin
            w_next_state = PAUSE;
          end else if (io_bus.i_tick) begin
            if (r_frame_cnt == LAST_FRAME) begin
              w_next_frame_cnt = '0;
              w_next_secs      = r_secs - SEC_W'(1);
              if (r_secs == SEC_W'(1)) begin
                w_next_state = EXPIRED;
                w_expire_now = 1'b1;
              end
            end else begin
              w_next_frame_cnt = r_frame_cnt + FRAME_W'(1);
            end
          end
        end
        PAUSE: begin
          if (!io_bus.i_pause) begin
            w_next_state = RUN;
          end
        end
        EXPIRED: begin
          if (io_bus.i_ack) begin
            w_next_state = IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_secs      <= '0;
      r_frame_cnt <= '0;
      r_tick_en   <= 1'b0;
      r_expired   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_secs      <= w_next_secs;
      r_frame_cnt <= w_next_frame_cnt;
      r_tick_en   <= (w_next_state == RUN);
      r_expired   <= w_expire_now;
    end
  end

  // Tens digit by threshold search so no divider is built; seconds never exceed 99
  always_comb begin
    w_tens = '0;
    for (int t = 1; t <= 9; t++) begin
      if (r_secs >= SEC_W'(t * 10)) begin
        w_tens = 4'(t);
      end
    end
  end

  assign io_bus.o_tick_en   = r_tick_en;
  assign io_bus.o_secs_left = r_secs;
  assign io_bus.o_bcd_tens  = w_tens;
  assign io_bus.o_bcd_ones  = 4'(r_secs - SEC_W'(w_tens) * SEC_W'(10));
  assign io_bus.o_state     = r_state;
  assign io_bus.o_busy      = (r_state == RUN) || (r_state == PAUSE);
  assign io_bus.o_expired   = r_expired;

`ifdef FRAME_TIMER_WARN_EN
  logic r_warn;

  // Registered from next-state values so it lines up with o_secs_left
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_warn <= 1'b0;
    end else begin
      r_warn <= (w_next_state == RUN) && (w_next_secs != '0) && (w_next_secs <= SEC_W'(5));
    end
  end

  assign io_bus.o_warn = r_warn;
`endif

endmodule

// File: tb/tb_frame_countdown_timer.sv
// Directed plus randomized bench for frame_countdown_timer; the reference model tracks
// total frame ticks remaining and derives seconds as a ceiling division.
module tb_frame_countdown_timer;

  localparam int FPS       = 60;
  localparam int SEC_W     = 7;
  localparam int MAXS      = 99;
  localparam int M_IDLE    = 0;
  localparam int M_RUN     = 1;
  localparam int M_PAUSE   = 2;
  localparam int M_EXPIRED = 3;

  logic clk;
  logic reset;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  int mMode;
  int mTicksLeft;
  int mPulse;

  frame_countdown_timer_if #(.SEC_W(SEC_W)) bus ();

  frame_countdown_timer #(
    .FRAMES_PER_SEC(FPS),
    .SEC_W         (SEC_W),
    .MAX_SECS      (MAXS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io_bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int expSecs();
    return (mTicksLeft + FPS - 1) / FPS;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mMode      = M_IDLE;
    mTicksLeft = 0;
    mPulse     = 0;
  endtask

  // Rules applied at one clock edge: start, then ack, then pause, then tick
  task automatic modelStep(input bit st, input bit ak, input bit pa, input bit tk, input int ld);
    int c;
    mPulse = 0;
    if (st) begin
      c          = (ld > MAXS) ? MAXS : ld;
      mTicksLeft = c * FPS;
      if (c == 0) begin
        mMode  = M_EXPIRED;
        mPulse = 1;
      end else begin
        mMode = M_RUN;
      end
    end else if (mMode == M_EXPIRED) begin
      if (ak) mMode = M_IDLE;
    end else if (mMode == M_RUN) begin
      if (pa) begin
        mMode = M_PAUSE;
      end else if (tk) begin
        mTicksLeft--;
        if (mTicksLeft == 0) begin
          mMode  = M_EXPIRED;
          mPulse = 1;
        end
      end
    end else if (mMode == M_PAUSE) begin
      if (!pa) mMode = M_RUN;
    end
  endtask

  task automatic checkOutput(input string step);
    int s;
    s = expSecs();
    checkVal({step, " state"},   32'(bus.o_state),     32'(mMode));
    checkVal({step, " secs"},    32'(bus.o_secs_left), 32'(s));
    checkVal({step, " tens"},    32'(bus.o_bcd_tens),  32'(s / 10));
    checkVal({step, " ones"},    32'(bus.o_bcd_ones),  32'(s % 10));
    checkVal({step, " busy"},    32'(bus.o_busy),      32'((mMode == M_RUN) || (mMode == M_PAUSE)));
    checkVal({step, " tick_en"}, 32'(bus.o_tick_en),   32'(mMode == M_RUN));
    checkVal({step, " expired"}, 32'(bus.o_expired),   32'(mPulse));
`ifdef FRAME_TIMER_WARN_EN
    checkVal({step, " warn"},    32'(bus.o_warn),      32'((mMode == M_RUN) && (s >= 1) && (s <= 5)));
`endif
  endtask

  // Called just after a rising edge: drive inputs, clock once, update the model, check
  task automatic applyStimulus(input string step, input bit st, input bit ak, input bit pa,
                               input bit tk, input int ld);
    bus.i_start     = st;
    bus.i_ack       = ak;
    bus.i_pause     = pa;
    bus.i_tick      = tk;
    bus.i_load_secs = 7'(ld);
    @(posedge clk);
    #1;
    modelStep(st, ak, pa, tk, ld);
    bus.i_start = 1'b0;
    bus.i_ack   = 1'b0;
    bus.i_tick  = 1'b0;
    checkOutput(step);
  endtask

  initial begin
    bit st;
    bit ak;
    bit pa;
    bit tk;
    int ld;

    bus.i_start     = 1'b0;
    bus.i_ack       = 1'b0;
    bus.i_pause     = 1'b0;
    bus.i_tick      = 1'b0;
    bus.i_load_secs = '0;
    reset           = 1'b1;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_hold");
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("after_reset");

    // Ticks, pause and ack in IDLE have no effect
    applyStimulus("idle_tick", 0, 0, 0, 1, 0);
    applyStimulus("idle_pause", 0, 0, 1, 1, 0);
    applyStimulus("idle_ack", 0, 1, 0, 0, 0);

    // Three-second run with a tick every fourth clock
    applyStimulus("start3", 1, 0, 0, 0, 3);
    checkVal("start3 secs direct", 32'(bus.o_secs_left), 32'd3);
    for (int i = 1; i <= 180; i++) begin
      applyStimulus("cd_tick", 0, 0, 0, 1, 0);
      if (i == 59)  checkVal("cd secs before first wrap", 32'(bus.o_secs_left), 32'd3);
      if (i == 60)  checkVal("cd secs after 60 ticks", 32'(bus.o_secs_left), 32'd2);
      if (i == 120) checkVal("cd secs after 120 ticks", 32'(bus.o_secs_left), 32'd1);
      if (i == 180) begin
        checkVal("cd expired pulse", 32'(bus.o_expired), 32'd1);
        checkVal("cd expired state", 32'(bus.o_state), 32'd3);
      end
      if (i < 180) for (int g = 0; g < 3; g++) applyStimulus("cd_gap", 0, 0, 0, 0, 0);
    end
    applyStimulus("exp_tick", 0, 0, 0, 1, 0);
    checkVal("expired single pulse", 32'(bus.o_expired), 32'd0);
    applyStimulus("exp_pause", 0, 0, 1, 0, 0);
    applyStimulus("ack", 0, 1, 0, 0, 0);
    checkVal("ack to idle", 32'(bus.o_state), 32'd0);
    applyStimulus("ack2", 0, 1, 0, 0, 0);

    // Load clamp
    applyStimulus("load120", 1, 0, 0, 0, 120);
    checkVal("clamp secs", 32'(bus.o_secs_left), 32'd99);
    checkVal("clamp tens", 32'(bus.o_bcd_tens), 32'd9);
    checkVal("clamp ones", 32'(bus.o_bcd_ones), 32'd9);
    applyStimulus("load127", 1, 0, 0, 0, 127);

    // Pause at frame 30, keep ticking while paused, then resume from frame 30
    applyStimulus("start2", 1, 0, 0, 0, 2);
    for (int i = 0; i < 30; i++) applyStimulus("pre_pause_tick", 0, 0, 0, 1, 0);
    for (int i = 0; i < 100; i++) applyStimulus("paused", 0, 0, 1, 1, 0);
    checkVal("paused state", 32'(bus.o_state), 32'd2);
    checkVal("paused tick_en", 32'(bus.o_tick_en), 32'd0);
    applyStimulus("resume", 0, 0, 0, 0, 0);
    checkVal("resume state", 32'(bus.o_state), 32'd1);
    for (int i = 1; i <= 30; i++) begin
      applyStimulus("post_pause_tick", 0, 0, 0, 1, 0);
      if (i == 29) checkVal("resume held frame", 32'(bus.o_secs_left), 32'd2);
      if (i == 30) checkVal("resume wrap", 32'(bus.o_secs_left), 32'd1);
    end

    // Zero load expires at once, from RUN
    applyStimulus("load0", 1, 0, 0, 0, 0);
    checkVal("load0 state", 32'(bus.o_state), 32'd3);
    checkVal("load0 pulse", 32'(bus.o_expired), 32'd1);
    checkVal("load0 tick_en", 32'(bus.o_tick_en), 32'd0);
    applyStimulus("load0_hold", 0, 0, 0, 1, 0);
    applyStimulus("load0_ack", 0, 1, 0, 0, 0);

    // start with a coincident tick: tick dropped, frame count begins at zero
    applyStimulus("start_tick", 1, 0, 0, 1, 5);
    for (int i = 1; i <= 60; i++) begin
      applyStimulus("st_tick", 0, 0, 0, 1, 0);
      if (i == 59) checkVal("start_tick frame zero", 32'(bus.o_secs_left), 32'd5);
      if (i == 60) checkVal("start_tick wrap", 32'(bus.o_secs_left), 32'd4);
    end

    // Randomized mix of all inputs, mostly short loads so expiries occur
    pa = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      st = ($urandom_range(0, 59) == 0);
      ld = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 2));
      ak = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) pa = ~pa;
      tk = ($urandom_range(0, 1) == 1);
      applyStimulus("rand", st, ak, pa, tk, ld);
    end

    // Asynchronous reset in the middle of a run
    applyStimulus("start5", 1, 0, 0, 0, 5);
    for (int i = 0; i < 10; i++) applyStimulus("pre_reset_tick", 0, 0, 0, 1, 0);
    #2 reset = 1'b1;
    #1;
    modelReset();
    checkOutput("async_reset");
    checkVal("async_reset tick_en", 32'(bus.o_tick_en), 32'd0);
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_reset");
    applyStimulus("post_reset_tick", 0, 0, 0, 1, 0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
